bus_cycle_controller: RTL

- Synchronous 68030 bus-cycle sequencer. Sits beside the address decoder in the system controller CPLD.
- Takes the decoded device selects and produces the cycle-termination signals: DSACK0_n/DSACK1_n, BERR_n, AVEC_n.
- Inserts per-device programmable wait states, times IDE read/write strobes, waits on the DUART's DTACK, and passes through the FPU's own DSACKs.
- Runs a bus-timeout watchdog that terminates unclaimed cycles with BERR.

---
 rtl/bus_cycle_controller_if.sv | 38 +++
 rtl/bus_cycle_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bus_cycle_controller_if.sv
// 68030 bus-side signal bundle between the CPU/decoder side and the cycle controller.
// The slave modport is the controller's view; master is the CPU, decoder and peripherals.
interface bus_cycle_controller_if;
  logic AS_n;
  logic DS_n;
  logic RW;
  logic SEL_ROM;
  logic SEL_SRAM;
  logic SEL_DUART;
  logic SEL_IDE;
  logic SEL_FPU;
  logic IACK_DUART;
  logic IACK_OTHER;
  logic DTACK_DUART_n;
  logic DSACK0_FPU_n;
  logic DSACK1_FPU_n;
  logic DSACK0_n;
  logic DSACK1_n;
  logic BERR_n;
  logic AVEC_n;
  logic IDE_RD_n;
  logic IDE_WR_n;
  logic BUSY;

  modport slave (
    input  AS_n, DS_n, RW,
    input  SEL_ROM, SEL_SRAM, SEL_DUART, SEL_IDE, SEL_FPU, IACK_DUART, IACK_OTHER,
    input  DTACK_DUART_n, DSACK0_FPU_n, DSACK1_FPU_n,
    output DSACK0_n, DSACK1_n, BERR_n, AVEC_n, IDE_RD_n, IDE_WR_n, BUSY
  );

  modport master (
    output AS_n, DS_n, RW,
    output SEL_ROM, SEL_SRAM, SEL_DUART, SEL_IDE, SEL_FPU, IACK_DUART, IACK_OTHER,
    output DTACK_DUART_n, DSACK0_FPU_n, DSACK1_FPU_n,
    input  DSACK0_n, DSACK1_n, BERR_n, AVEC_n, IDE_RD_n, IDE_WR_n, BUSY
  );
endinterface

// File: rtl/bus_cycle_controller.sv
// 68030 bus-cycle sequencer: wait states, DTACK/FPU termination, IDE strobes and BERR watchdog.
// Device selects are latched at cycle start; all sequencing uses the synchronised AS_n/DTACK_n.
module bus_cycle_controller #(
  parameter int ROM_WAIT   = 3,
  parameter int SRAM_WAIT  = 0,
  parameter int IDE_WAIT   = 4,
  parameter int TMO_CYCLES = 200,
  parameter int CNT_W      = 8
) (
  input logic CLK,
  input logic RST_n,
  bus_cycle_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DTACK,
    ST_ACK,
    ST_FAULT
  } state_e;

  localparam int S_ROM   = 0;
  localparam int S_SRAM  = 1;
  localparam int S_DUART = 2;
  localparam int S_IDE   = 3;
  localparam int S_FPU   = 4;
  localparam int S_IACKD = 5;
  localparam int S_IACKO = 6;

  state_e             state_q, state_d;
  logic               as_meta_q, as_meta_d, as_s_q, as_s_d;
  logic               dt_meta_q, dt_meta_d, dtack_s_q, dtack_s_d;
  logic [6:0]         sel_q, sel_d, sel_in;
  logic [CNT_W-1:0]   wait_q, wait_d, tmo_q, tmo_d, tmo_inc;
  logic               wait_en_q, wait_en_d;
  logic               tmo_hit, in_ack, fpu_pass, strobe_ok, ack8;

  assign sel_in = {bus.IACK_OTHER, bus.IACK_DUART, bus.SEL_FPU, bus.SEL_IDE,
                   bus.SEL_DUART, bus.SEL_SRAM, bus.SEL_ROM};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      as_meta_q <= 1'b1;
      as_s_q    <= 1'b1;
      dt_meta_q <= 1'b1;
      dtack_s_q <= 1'b1;
      sel_q     <= '0;
      wait_q    <= '0;
      tmo_q     <= '0;
      wait_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      as_meta_q <= as_meta_d;
      as_s_q    <= as_s_d;
      dt_meta_q <= dt_meta_d;
      dtack_s_q <= dtack_s_d;
      sel_q     <= sel_d;
      wait_q    <= wait_d;
      tmo_q     <= tmo_d;
      wait_en_q <= wait_en_d;
    end
  end

  always_comb begin
    as_meta_d = bus.AS_n;
    as_s_d    = as_meta_q;
    dt_meta_d = bus.DTACK_DUART_n;
    dtack_s_d = dt_meta_q;
    state_d   = state_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    wait_en_d = wait_en_q;
    tmo_hit   = (tmo_q == CNT_W'(TMO_CYCLES));
    tmo_inc   = (&tmo_q) ? tmo_q : tmo_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (!as_s_q) begin
          sel_d     = sel_in;
          tmo_d     = '0;
          wait_d    = '0;
          wait_en_d = 1'b0;
          if (!$onehot0(sel_in)) begin
            state_d = ST_FAULT;
          end else if (sel_in[S_ROM]) begin
            state_d   = ST_WAIT;
            wait_d    = CNT_W'(ROM_WAIT);
            wait_en_d = 1'b1;
          end else if (sel_in[S_SRAM]) begin
            state_d   = ST_WAIT;
            wait_d    = CNT_W'(SRAM_WAIT);
            wait_en_d = 1'b1;
          end else if (sel_in[S_IDE]) begin
            state_d   = ST_WAIT;
            wait_d    = CNT_W'(IDE_WAIT);
            wait_en_d = 1'b1;
          end else if (sel_in[S_DUART] || sel_in[S_IACKD]) begin
            state_d = ST_DTACK;
          end else if (sel_in[S_IACKO] || sel_in[S_FPU]) begin
            state_d = ST_ACK;
          end else begin
            // Unmapped address: only the watchdog can end this cycle
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (as_s_q) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_inc;
          if (wait_en_q) begin
            if (wait_q == '0) state_d = ST_ACK;
            else              wait_d  = wait_q - CNT_W'(1);
          end
        end
      end
      ST_DTACK: begin
        if (as_s_q) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_inc;
          if (!dtack_s_q) state_d = ST_ACK;
        end
      end
      ST_ACK, ST_FAULT: begin
        if (as_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FPU acknowledges and IDE strobes use the raw strobes so they drop the instant the CPU lets go
  assign in_ack    = (state_q == ST_ACK);
  assign ack8      = in_ack && (sel_q[S_ROM] || sel_q[S_SRAM] || sel_q[S_DUART] || sel_q[S_IACKD]);
  assign fpu_pass  = in_ack && sel_q[S_FPU] && !bus.AS_n;
  assign strobe_ok = sel_q[S_IDE] && (state_q == ST_WAIT || state_q == ST_ACK)
                     && !bus.AS_n && !bus.DS_n;

  assign bus.DSACK0_n = fpu_pass ? bus.DSACK0_FPU_n : !ack8;
  assign bus.DSACK1_n = fpu_pass ? bus.DSACK1_FPU_n : !(in_ack && sel_q[S_IDE]);
  assign bus.AVEC_n   = !(in_ack && sel_q[S_IACKO]);
  assign bus.BERR_n   = (state_q != ST_FAULT);
  assign bus.IDE_RD_n = !(strobe_ok && bus.RW);
  assign bus.IDE_WR_n = !(strobe_ok && !bus.RW);
  assign bus.BUSY     = (state_q != ST_IDLE);

endmodule
